// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared types and sizing for the operand collector
`ifndef COLLECTOR_SIZE
`define COLLECTOR_SIZE 4
`endif
`ifndef RS_INDEX
`define RS_INDEX 3
`endif
`ifndef BANK_NUM
`define BANK_NUM 4
`endif

package gelato_types;
  localparam int NUM_ENTRIES  = `COLLECTOR_SIZE;
  localparam int NUM_OPERANDS = `RS_INDEX;
  localparam int NUM_BANKS    = `BANK_NUM;

  typedef logic [2:0]  warp_num_t;
  typedef logic [4:0]  reg_num_t;
  typedef logic [31:0] warp_reg_t;
  typedef logic [$clog2(NUM_ENTRIES)-1:0]  collector_num_t;
  typedef logic [$clog2(NUM_OPERANDS)-1:0] rs_num_t;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    COLLECTING = 2'd1,
    READY      = 2'd2
  } collector_state_t;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic collector_num_t first_set(input logic [NUM_ENTRIES-1:0] v);
    first_set = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (v[e]) first_set = collector_num_t'(e);
    end
  endfunction
endpackage

// File: rtl/gelato_register_collect_if.sv
// rtl/gelato_register_collect_if.sv - request/response bundles between collector and RF arbiter
interface gelato_register_collect_request_if;
  import gelato_types::*;
  logic                                         valid;
  logic           [NUM_ENTRIES-1:0]             entry_valid;
  warp_num_t      [NUM_ENTRIES-1:0]             warp_num;
  reg_num_t       [NUM_ENTRIES-1:0][NUM_OPERANDS-1:0] reg_num;
  logic           [NUM_ENTRIES-1:0][NUM_OPERANDS-1:0] reg_valid;
  collector_num_t [NUM_ENTRIES-1:0]             collector_num;

  modport master (output valid, entry_valid, warp_num, reg_num, reg_valid, collector_num);
  modport slave  (input  valid, entry_valid, warp_num, reg_num, reg_valid, collector_num);
endinterface

interface gelato_register_collect_response_if;
  import gelato_types::*;
  logic                             valid;
  logic           [NUM_BANKS-1:0]   data_valid;
  warp_reg_t      [NUM_BANKS-1:0]   data;
  collector_num_t [NUM_BANKS-1:0]   collector_index;
  rs_num_t        [NUM_BANKS-1:0]   reg_index;

  modport master (output valid, data_valid, data, collector_index, reg_index);
  modport slave  (input  valid, data_valid, data, collector_index, reg_index);
endinterface

// File: rtl/gelato_collector_entry.sv
// rtl/gelato_collector_entry.sv - one collector slot: state, pending operands and captured data
module gelato_collector_entry
  import gelato_types::*;
#(
  parameter int ENTRY_ID = 0,
  parameter int RS_NUM   = 3,
  parameter int BANKS    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_en,
  input  warp_num_t                         alloc_warp_num,
  input  reg_num_t       [RS_NUM-1:0]       alloc_reg_num,
  input  logic           [RS_NUM-1:0]       alloc_reg_valid,
  input  logic                              dispatch_en,
  input  logic                              rsp_valid,
  input  logic           [BANKS-1:0]        rsp_data_valid,
  input  collector_num_t [BANKS-1:0]        rsp_collector_index,
  input  rs_num_t        [BANKS-1:0]        rsp_reg_index,
  input  warp_reg_t      [BANKS-1:0]        rsp_data,
  output logic                              is_free,
  output logic                              is_ready,
  output logic                              entry_valid,
  output logic           [RS_NUM-1:0]       pending,
  output warp_num_t                         warp_num,
  output reg_num_t       [RS_NUM-1:0]       reg_num,
  output warp_reg_t      [RS_NUM-1:0]       data
);
  collector_state_t            state_q, state_d;
  logic       [RS_NUM-1:0]     pending_q, pending_d, hit;
  warp_num_t                   warp_q;
  reg_num_t   [RS_NUM-1:0]     reg_q;
  warp_reg_t  [RS_NUM-1:0]     data_q, data_d;

  // Banks are scanned upward so the highest bank wins a same-operand collision.
  always_comb begin
    hit    = '0;
    data_d = data_q;
    for (int b = 0; b < BANKS; b++) begin
      if (rsp_valid && rsp_data_valid[b] && state_q == COLLECTING &&
          rsp_collector_index[b] == collector_num_t'(ENTRY_ID)) begin
        for (int i = 0; i < RS_NUM; i++) begin
          if (rsp_reg_index[b] == rs_num_t'(i) && pending_q[i]) begin
            hit[i]    = 1'b1;
            data_d[i] = rsp_data[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FREE;
      pending_q <= '0;
      warp_q    <= '0;
      reg_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      if (state_q == FREE && alloc_en) begin
        warp_q <= alloc_warp_num;
        reg_q  <= alloc_reg_num;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      FREE: begin
        if (alloc_en) begin
          state_d   = COLLECTING;
          pending_d = alloc_reg_valid;
        end
      end
      COLLECTING: begin
        pending_d = pending_q & ~hit;
        if (pending_d == '0) state_d = READY;
      end
      READY: begin
        if (dispatch_en) state_d = FREE;
      end
      default: begin
        state_d   = FREE;
        pending_d = '0;
      end
    endcase
  end

  always_comb begin
    is_free     = (state_q == FREE);
    is_ready    = (state_q == READY);
    entry_valid = (state_q == COLLECTING) && (|pending_q);
    pending     = pending_q;
    warp_num    = warp_q;
    reg_num     = reg_q;
    data        = data_q;
  end
endmodule

// File: rtl/gelato_operand_collector.sv
// rtl/gelato_operand_collector.sv - operand collector: allocates, gathers RF operands, dispatches
`ifndef COLLECTOR_SIZE
`define COLLECTOR_SIZE 4
`endif
`ifndef RS_INDEX
`define RS_INDEX 3
`endif
`ifndef BANK_NUM
`define BANK_NUM 4
`endif

module gelato_operand_collector
  import gelato_types::*;
#(
  parameter int COLLECTOR_SIZE = `COLLECTOR_SIZE,
  parameter int RS_INDEX       = `RS_INDEX,
  parameter int BANK_NUM       = `BANK_NUM
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  warp_num_t                         alloc_warp_num,
  input  reg_num_t       [RS_INDEX-1:0]     alloc_reg_num,
  input  logic           [RS_INDEX-1:0]     alloc_reg_valid,
  gelato_register_collect_request_if.master req,
  gelato_register_collect_response_if.slave rsp,
  output logic                              disp_valid,
  input  logic                              disp_ready,
  output warp_num_t                         disp_warp_num,
  output warp_reg_t      [RS_INDEX-1:0]     disp_data,
  output collector_num_t                    disp_collector
);
  logic           [COLLECTOR_SIZE-1:0]               free_vec, ready_vec, entry_valid_vec;
  logic           [COLLECTOR_SIZE-1:0]               alloc_en, dispatch_en;
  logic           [COLLECTOR_SIZE-1:0][RS_INDEX-1:0] pending_vec;
  warp_num_t      [COLLECTOR_SIZE-1:0]               warp_vec;
  reg_num_t       [COLLECTOR_SIZE-1:0][RS_INDEX-1:0] reg_vec;
  warp_reg_t      [COLLECTOR_SIZE-1:0][RS_INDEX-1:0] data_vec;
  collector_num_t [COLLECTOR_SIZE-1:0]               id_vec;

  logic           init_q, hold_q;
  collector_num_t hold_idx_q, alloc_idx, disp_sel;
  logic           alloc_fire, disp_fire;

  genvar e;
  generate
    for (e = 0; e < COLLECTOR_SIZE; e++) begin : g_entry
      gelato_collector_entry #(
        .ENTRY_ID (e),
        .RS_NUM   (RS_INDEX),
        .BANKS    (BANK_NUM)
      ) u_entry (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_en            (alloc_en[e]),
        .alloc_warp_num      (alloc_warp_num),
        .alloc_reg_num       (alloc_reg_num),
        .alloc_reg_valid     (alloc_reg_valid),
        .dispatch_en         (dispatch_en[e]),
        .rsp_valid           (rsp.valid),
        .rsp_data_valid      (rsp.data_valid),
        .rsp_collector_index (rsp.collector_index),
        .rsp_reg_index       (rsp.reg_index),
        .rsp_data            (rsp.data),
        .is_free             (free_vec[e]),
        .is_ready            (ready_vec[e]),
        .entry_valid         (entry_valid_vec[e]),
        .pending             (pending_vec[e]),
        .warp_num            (warp_vec[e]),
        .reg_num             (reg_vec[e]),
        .data                (data_vec[e])
      );
      assign alloc_en[e]    = alloc_fire && (alloc_idx == collector_num_t'(e));
      assign dispatch_en[e] = disp_fire && (disp_sel == collector_num_t'(e));
      assign id_vec[e]      = collector_num_t'(e);
    end
  endgenerate

  // init_q keeps alloc_ready low until the first edge after reset releases.
  assign alloc_idx   = first_set(free_vec);
  assign alloc_ready = init_q && (|free_vec);
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Once an offer stalls, the same entry stays selected even if a lower one turns READY.
  assign disp_sel       = hold_q ? hold_idx_q : first_set(ready_vec);
  assign disp_valid     = |ready_vec;
  assign disp_fire      = disp_valid && disp_ready;
  assign disp_warp_num  = warp_vec[disp_sel];
  assign disp_data      = data_vec[disp_sel];
  assign disp_collector = disp_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q     <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      init_q     <= 1'b1;
      hold_q     <= disp_valid && !disp_ready;
      hold_idx_q <= disp_sel;
    end
  end

  assign req.valid         = |entry_valid_vec;
  assign req.entry_valid   = entry_valid_vec;
  assign req.reg_valid     = pending_vec;
  assign req.warp_num      = warp_vec;
  assign req.reg_num       = reg_vec;
  assign req.collector_num = id_vec;
endmodule

// File: tb/tb_gelato_operand_collector.sv
// tb/tb_gelato_operand_collector.sv - directed self-checking bench for gelato_operand_collector
module tb_gelato_operand_collector;
  import gelato_types::*;

  logic                               clk;
  logic                               rst;
  logic                               alloc_valid;
  logic                               alloc_ready;
  warp_num_t                          alloc_warp_num;
  reg_num_t       [NUM_OPERANDS-1:0]  alloc_reg_num;
  logic           [NUM_OPERANDS-1:0]  alloc_reg_valid;
  logic                               disp_valid;
  logic                               disp_ready;
  warp_num_t                          disp_warp_num;
  warp_reg_t      [NUM_OPERANDS-1:0]  disp_data;
  collector_num_t                     disp_collector;

  int n_cmp = 0;
  int n_err = 0;

  gelato_register_collect_request_if  req_if ();
  gelato_register_collect_response_if rsp_if ();

  gelato_operand_collector dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_warp_num  (alloc_warp_num),
    .alloc_reg_num   (alloc_reg_num),
    .alloc_reg_valid (alloc_reg_valid),
    .req             (req_if),
    .rsp             (rsp_if),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_warp_num   (disp_warp_num),
    .disp_data       (disp_data),
    .disp_collector  (disp_collector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input int warp, input int r2, input int r1, input int r0,
                           input logic [2:0] vld);
    alloc_valid      = 1'b1;
    alloc_warp_num   = warp_num_t'(warp);
    alloc_reg_num[2] = reg_num_t'(r2);
    alloc_reg_num[1] = reg_num_t'(r1);
    alloc_reg_num[0] = reg_num_t'(r0);
    alloc_reg_valid  = vld;
  endtask

  task automatic clear_rsp();
    rsp_if.valid           = 1'b0;
    rsp_if.data_valid      = '0;
    rsp_if.data            = '0;
    rsp_if.collector_index = '0;
    rsp_if.reg_index       = '0;
  endtask

  task automatic set_lane(input int b, input int coll, input int ri, input logic [31:0] d);
    rsp_if.valid              = 1'b1;
    rsp_if.data_valid[b]      = 1'b1;
    rsp_if.collector_index[b] = collector_num_t'(coll);
    rsp_if.reg_index[b]       = rs_num_t'(ri);
    rsp_if.data[b]            = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_warp_num = '0;
    alloc_reg_num = '0;
    alloc_reg_valid = '0;
    disp_ready = 1'b0;
    clear_rsp();
    tick();
    tick();
    check_eq("rst_alloc_ready", alloc_ready, 0);
    check_eq("rst_disp_valid", disp_valid, 0);
    check_eq("rst_req_valid", req_if.valid, 0);
    check_eq("rst_entry_valid", req_if.entry_valid, 0);
    check_eq("rst_reg_valid", req_if.reg_valid, 0);
    rst = 1'b0;
    #1;
    check_eq("release_before_edge", alloc_ready, 0);
    tick();
    check_eq("release_after_edge", alloc_ready, 1);

    // Two operands returned by banks 1 and 3 in one cycle.
    set_alloc(2, 0, 7, 5, 3'b011);
    tick();
    alloc_valid = 1'b0;
    check_eq("a_entry_valid", req_if.entry_valid, 4'b0001);
    check_eq("a_req_valid", req_if.valid, 1);
    check_eq("a_reg_valid0", req_if.reg_valid[0], 3'b011);
    check_eq("a_warp0", req_if.warp_num[0], 2);
    check_eq("a_reg01", req_if.reg_num[0][1], 7);
    check_eq("a_reg00", req_if.reg_num[0][0], 5);
    check_eq("a_coll_num3", req_if.collector_num[3], 3);
    check_eq("a_disp_early", disp_valid, 0);
    set_lane(1, 0, 0, 32'hAAAA0001);
    set_lane(3, 0, 1, 32'hBBBB0002);
    tick();
    clear_rsp();
    check_eq("a_disp_valid", disp_valid, 1);
    check_eq("a_disp_coll", disp_collector, 0);
    check_eq("a_disp_warp", disp_warp_num, 2);
    check_eq("a_disp_d0", disp_data[0], 32'hAAAA0001);
    check_eq("a_disp_d1", disp_data[1], 32'hBBBB0002);
    check_eq("a_entry_idle", req_if.entry_valid, 0);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check_eq("a_after_disp", disp_valid, 0);

    // Zero-operand instruction.
    set_alloc(5, 0, 0, 0, 3'b000);
    tick();
    alloc_valid = 1'b0;
    check_eq("c_no_request", req_if.entry_valid, 0);
    check_eq("c_disp_1cyc", disp_valid, 0);
    tick();
    check_eq("c_disp_2cyc", disp_valid, 1);
    check_eq("c_disp_warp", disp_warp_num, 5);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;

    // Fill all four entries, then free entry 2 while alloc_valid is held.
    for (int k = 0; k < 4; k++) begin
      set_alloc(k, 0, 0, 10 + k, 3'b001);
      tick();
    end
    set_alloc(6, 0, 0, 20, 3'b001);
    check_eq("b_full", alloc_ready, 0);
    set_lane(0, 2, 0, 32'h22);
    tick();
    clear_rsp();
    check_eq("b_disp_coll", disp_collector, 2);
    disp_ready = 1'b1;
    check_eq("b_free_same_cycle", alloc_ready, 0);
    tick();
    disp_ready = 1'b0;
    check_eq("b_free_next_cycle", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    check_eq("b_landed_warp", req_if.warp_num[2], 6);
    check_eq("b_landed_reg", req_if.reg_num[2][0], 20);
    check_eq("b_all_collect", req_if.entry_valid, 4'b1111);
    check_eq("b_full_again", alloc_ready, 0);

    // Entries 1 and 3 READY, offer stalled three cycles.
    set_lane(0, 1, 0, 32'h11);
    set_lane(1, 3, 0, 32'h33);
    tick();
    clear_rsp();
    for (int s = 0; s < 3; s++) begin
      check_eq("d_stall_coll", disp_collector, 1);
      check_eq("d_stall_warp", disp_warp_num, 1);
      if (s < 2) tick();
    end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check_eq("d_next_coll", disp_collector, 3);
    check_eq("d_next_warp", disp_warp_num, 3);
    set_lane(0, 0, 0, 32'h0);
    tick();
    clear_rsp();
    check_eq("d_hold_vs_lower", disp_collector, 3);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check_eq("d_then_entry0", disp_collector, 0);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;

    // Concurrent alloc/response, then duplicate and stale responses.
    set_alloc(4, 0, 2, 1, 3'b011);
    set_lane(0, 2, 0, 32'h66);
    tick();
    alloc_valid = 1'b0;
    clear_rsp();
    check_eq("e_entry_valid", req_if.entry_valid, 4'b0001);
    check_eq("e_disp_coll", disp_collector, 2);
    check_eq("e_disp_d0", disp_data[0], 32'h66);
    disp_ready = 1'b1;
    set_lane(0, 0, 0, 32'h0000000A);
    set_lane(2, 0, 0, 32'h0000000B);
    tick();
    disp_ready = 1'b0;
    clear_rsp();
    check_eq("e_dup_pending", req_if.reg_valid[0], 3'b010);
    check_eq("e_disp_gone", disp_valid, 0);
    set_lane(1, 0, 1, 32'h0000000C);
    set_lane(2, 0, 0, 32'h00000BAD);
    set_lane(3, 2, 0, 32'h0000DEAD);
    tick();
    clear_rsp();
    check_eq("e_ready", disp_valid, 1);
    check_eq("e_coll", disp_collector, 0);
    check_eq("e_dup_high_bank", disp_data[0], 32'h0000000B);
    check_eq("e_d1", disp_data[1], 32'h0000000C);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check_eq("e_free_ignored", disp_valid, 0);
    check_eq("e_alloc_ready", alloc_ready, 1);

    // Reset during collection.
    set_alloc(1, 9, 0, 0, 3'b100);
    tick();
    set_alloc(7, 0, 0, 3, 3'b001);
    tick();
    alloc_valid = 1'b0;
    check_eq("f_entry_valid", req_if.entry_valid, 4'b0011);
    check_eq("f_reg_valid0", req_if.reg_valid[0], 3'b100);
    rst = 1'b1;
    #1;
    check_eq("f_rst_req_valid", req_if.valid, 0);
    check_eq("f_rst_entry_valid", req_if.entry_valid, 0);
    check_eq("f_rst_reg_valid", req_if.reg_valid, 0);
    check_eq("f_rst_alloc_ready", alloc_ready, 0);
    check_eq("f_rst_disp_valid", disp_valid, 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("f_release_low", alloc_ready, 0);
    tick();
    check_eq("f_release_high", alloc_ready, 1);
    set_lane(0, 0, 2, 32'h5555);
    set_lane(1, 1, 0, 32'h7777);
    tick();
    clear_rsp();
    check_eq("f_stale_disp", disp_valid, 0);
    check_eq("f_stale_req", req_if.valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gelato_operand_collector.md
GELATO_OPERAND_COLLECTOR -- requirements
Module: gelato_operand_collector

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- COLLECTOR_SIZE, `COLLECTOR_SIZE (4): number of collector entries.
- RS_INDEX, `RS_INDEX (3): source operands per entry.
- BANK_NUM, `BANK_NUM (4): number of response lanes.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  issue stage offers an instruction.
- alloc_ready  out  1  a free entry exists.
- alloc_warp_num  in  warp_num_t  warp of the instruction.
- alloc_reg_num  in  reg_num_t[RS_INDEX]  source registers.
- alloc_reg_valid  in  1[RS_INDEX]  operand is used.
- req  gelato_register_collect_request_if.master  request toward the RF arbiter.
- rsp  gelato_register_collect_response_if.slave  response from the RF arbiter.
- disp_valid  out  1  a fully collected entry is offered.
- disp_ready  in  1  execution accepts the offered entry.
- disp_warp_num  out  warp_num_t  warp of the dispatched entry.
- disp_data  out  warp_reg_t[RS_INDEX]  collected operands.
- disp_collector  out  collector_num_t  index of the dispatched entry.

Function
REQ-003 Each entry SHALL have a state FREE, COLLECTING or READY, plus per-operand pending bits, registers and data.
REQ-004 alloc_ready SHALL be asserted exactly when any entry is FREE at the start of the cycle.
REQ-005 On alloc_valid && alloc_ready, the lowest-index FREE entry SHALL load the warp and registers, set pending[i] = alloc_reg_valid[i], and move to COLLECTING.
REQ-006 A COLLECTING entry with no pending bits SHALL move to READY on the next edge; a zero-operand instruction therefore reaches READY 2 cycles after allocation.
REQ-007 req.entry_valid[e] SHALL be asserted exactly when entry e is COLLECTING with at least one pending bit.
REQ-008 req.reg_valid[e][i] SHALL equal pending[i] of entry e.
REQ-009 req.warp_num[e] and req.reg_num[e][i] SHALL reflect the stored fields of entry e.
REQ-010 req.collector_num[e] SHALL equal e.
REQ-011 req.valid SHALL be the OR of all req.entry_valid bits; all request outputs SHALL be combinational from state.
REQ-012 When rsp.valid is high, for each bank b with rsp.data_valid[b], the block SHALL write rsp.data[b] into entry rsp.collector_index[b], operand rsp.reg_index[b], and clear that pending bit at the edge.
REQ-013 A response targeting an entry that is not COLLECTING, or an operand that is not pending, SHALL be ignored.
REQ-014 Multiple banks hitting different operands of one entry in the same cycle SHALL all be accepted.
REQ-015 Multiple banks hitting the same operand in the same cycle SHALL resolve to the highest bank index.
REQ-016 An entry whose last pending bit clears SHALL become READY at that edge; the minimum latency from allocation to disp_valid is 2 cycles plus the response delay.
REQ-017 disp_valid SHALL select the lowest-index READY entry; its outputs SHALL remain stable while disp_valid && !disp_ready.
REQ-018 On disp_valid && disp_ready, the selected entry SHALL return to FREE at the edge.
REQ-019 An entry freed in a cycle SHALL NOT be allocatable until the next cycle.
REQ-020 Allocation, response and dispatch in the same cycle on different entries SHALL all take effect independently.

Reset
REQ-021 rst SHALL asynchronously force every entry to FREE and clear all pending bits.
REQ-022 While rst is asserted, alloc_ready=0, disp_valid=0, req.valid=0, all entry_valid=0 and all reg_valid=0.
REQ-023 alloc_ready SHALL rise on the first edge after rst deasserts.
REQ-024 Reset mid-collection SHALL discard all entries; responses arriving in later cycles SHALL be ignored under REQ-013.

Structure
REQ-025 The package gelato_types SHALL hold collector_state_t (FREE/COLLECTING/READY) alongside the existing warp_num_t, reg_num_t, warp_reg_t, collector_num_t and rs_num_t.
REQ-026 The macros COLLECTOR_SIZE, RS_INDEX and BANK_NUM SHALL be used from gelato_macros.
REQ-027 Per-entry state SHALL live in sub-module gelato_collector_entry, instantiated COLLECTOR_SIZE times.
REQ-028 Allocation and dispatch priority encoders SHALL live in the top level.

Verification
REQ-029 Allocate warp 2 with regs {5,7,-} (valid {1,1,0}) -> entry 0 requests; bank1 returns reg_index 0 and bank3 returns reg_index 1 in one cycle -> disp_valid next cycle with both data, disp_collector=0.
REQ-030 Allocate 4 instructions, then hold alloc_valid -> alloc_ready=0; dispatch entry 2 -> alloc_ready=1 one cycle later and the new instruction lands in entry 2.
REQ-031 Allocate with all reg_valid=0 -> req.entry_valid stays 0 and disp_valid rises 2 cycles after allocation.
REQ-032 Entries 1 and 3 both READY with disp_ready=0 for 3 cycles -> entry 1 is held stable, then dispatched, then entry 3 is offered.
REQ-033 Duplicate response on operand 0 from banks 0 and 2 with data A and B -> operand holds B; a later response to a FREE entry is ignored.
REQ-034 Assert rst while 2 entries are COLLECTING -> all outputs go low immediately, alloc_ready=1 after release, and stale responses have no effect.
